led_chase_monitor: RTL
======================

Name: led_chase_monitor

Overview:
- Receive-side companion to the right-shift LED chaser.
- Samples the 8-bit LED bus on qualified cycles, decodes the lit position and locks onto the sequence 1000_0000 -> 0100_0000 -> ... -> 0000_0001 -> 0000_0000 -> 1000_0000.
- Flags any illegal transition, counts completed laps and errors.
- Sits beside the chaser as a self-check/status block; all outputs are registered.

Parameters:
- WIDTH, 8, number of LEDs on the observed bus.
- POS_W, 4, width of the position output; must satisfy 2^POS_W > WIDTH.
- LAP_W, 8, lap counter width; counter wraps.
- ERR_W, 8, error counter width; counter saturates.

Ports:
- Clk  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- En  input  1  sample qualifier; LED_in is evaluated only on Clk edges with En=1.
- Clr  input  1  synchronous clear of Lap_cnt and Err_cnt.
- LED_in  input  WIDTH  observed LED bus; MSB is the first lit LED.
- Pos  output  POS_W  decoded position: 0 = MSB lit, WIDTH-1 = LSB lit, WIDTH = all off.
- Valid_pat  output  1  last sample was one-hot or all-zero.
- Locked  output  1  monitor is tracking the sequence.
- Lap_pulse  output  1  one-cycle pulse when a lap completes.
- Err_pulse  output  1  one-cycle pulse on a sequence error while locked.
- Lap_cnt  output  LAP_W  completed laps, modulo 2^LAP_W.
- Err_cnt  output  ERR_W  errors, saturating at all-ones.

Behaviour:
- Reset (RST=1, asynchronous):
  - Pos=0, Valid_pat=0, Locked=0, Lap_pulse=0, Err_pulse=0, Lap_cnt=0, Err_cnt=0.
  - State = UNLOCKED.
- Latency: outputs reflect a sample on the Clk edge where En=1 is seen; they are visible one cycle after the sampled inputs were applied.
- En=0 edges:
  - All state, Pos and Valid_pat hold.
  - Lap_pulse and Err_pulse go to 0.
- Decode:
  - legal = LED_in is one-hot or all-zero.
  - For a one-hot sample, position = WIDTH-1-(index of the set bit); all-zero gives position WIDTH.
  - Valid_pat <= legal on every En sample.
- Expected next position: (Pos == WIDTH) ? 0 : Pos+1.
- UNLOCKED state, on an En sample:
  - Legal sample: Pos <= decoded position. Illegal sample: Pos holds.
  - Sample == 1000_0000 (position 0): go to LOCKED, Locked <= 1.
  - Any other sample: stay UNLOCKED.
  - Never asserts Err_pulse or Lap_pulse.
- LOCKED state, on an En sample:
  - Sample position equals the expected next position: Pos <= expected.
  - Lap: if the transition is WIDTH -> 0 (all-off followed by MSB), Lap_pulse <= 1 and Lap_cnt increments.
  - Mismatch (illegal pattern, repeated pattern, skipped step, wrong direction): Err_pulse <= 1 and Err_cnt increments (saturating).
    - Mismatching sample == 1000_0000 (chaser reset mid-lap): stay LOCKED, Pos <= 0, no Lap_pulse.
    - Otherwise: go to UNLOCKED, Locked <= 0; Pos <= decoded position if legal, else Pos holds.
- Clr:
  - Clr=1 sets Lap_cnt=0 and Err_cnt=0 on that edge.
  - Clr has priority over a simultaneous increment; the pulses still fire.
  - Clr does not affect state, Pos or Locked.
- Counter boundaries:
  - Lap_cnt wraps from 2^LAP_W-1 to 0.
  - Err_cnt holds at 2^ERR_W-1.
- RST asserted mid-lap: immediate return to reset values; relocking requires a fresh 1000_0000 sample.

Test Plan:
- Clean sequence, En=1 every cycle, 3 full laps from 1000_0000 -> Locked=1 after the first sample; Pos steps 0..8; Lap_pulse at the 2nd and 3rd return to 1000_0000 only; Lap_cnt=2; Err_cnt=0.
- En=1 every 4th cycle with the LED changing only on sampled cycles -> identical Pos sequence and counts as the clean case; Pos holds and pulses stay 0 between samples.
- Locked at Pos=3 (0001_0000), then 0000_0100 is sampled -> Err_pulse for one cycle, Err_cnt=1, Locked=0, Pos=5. A later 1000_0000 sample -> Locked=1, Pos=0, no Lap_pulse.
- Locked at Pos=4, then 1000_0000 is sampled (chaser reset) -> Err_pulse=1, Err_cnt=1, Locked stays 1, Pos=0. A following 0100_0000 -> no error, Pos=1.
- Locked, then illegal 1100_0000 is sampled -> Valid_pat=0, Err_pulse=1, Locked=0, Pos unchanged. In UNLOCKED, further illegal samples -> no Err_pulse.
- Counter limits and Clr:
  - ERR_W=2: force 5 errors -> Err_cnt sticks at 3.
  - LAP_W=2: 5 laps -> Lap_cnt=1.
  - Clr asserted together with a lap completion -> Lap_cnt=0, Lap_pulse=1.
  - RST pulsed mid-lap -> all outputs 0 in the same cycle, asynchronously.

Source files
------------

// File: rtl/led_chase_monitor.sv
// ---------------------------------------------------------------------------------------------
// led_chase_monitor
//
// Receive-side checker for a right-shift LED chaser. On every qualified clock edge (En=1) the
// LED bus is decoded into a position, checked against the expected next step of the chase
// sequence 1000_0000 -> 0100_0000 -> ... -> 0000_0001 -> 0000_0000 -> 1000_0000 and the
// status outputs/counters are updated. All outputs are registered.
//
// Parameters:
//   WIDTH  number of LEDs on the observed bus
//   POS_W  width of the position output (2**POS_W must exceed WIDTH)
//   LAP_W  lap counter width (wraps)
//   ERR_W  error counter width (saturates)
//
// Ports:
//   Clk        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   En         in   sample qualifier
//   Clr        in   synchronous clear of Lap_cnt and Err_cnt
//   LED_in     in   observed LED bus, MSB is the first lit LED
//   Pos        out  decoded position: 0 = MSB lit, WIDTH-1 = LSB lit, WIDTH = all off
//   Valid_pat  out  last sample was one-hot or all-zero
//   Locked     out  monitor is tracking the sequence
//   Lap_pulse  out  one-cycle pulse on lap completion
//   Err_pulse  out  one-cycle pulse on a sequence error while locked
//   Lap_cnt    out  completed laps, modulo 2**LAP_W
//   Err_cnt    out  errors, saturating at all-ones
// ---------------------------------------------------------------------------------------------

module led_chase_monitor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned POS_W = 4,
    parameter int unsigned LAP_W = 8,
    parameter int unsigned ERR_W = 8
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             En,
    input  logic             Clr,
    input  logic [WIDTH-1:0] LED_in,
    output logic [POS_W-1:0] Pos,
    output logic             Valid_pat,
    output logic             Locked,
    output logic             Lap_pulse,
    output logic             Err_pulse,
    output logic [LAP_W-1:0] Lap_cnt,
    output logic [ERR_W-1:0] Err_cnt
);

    typedef enum logic [0:0] {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } state_e;

    localparam logic [POS_W-1:0] PosOff  = POS_W'(WIDTH);
    localparam logic [WIDTH-1:0] LedMsb  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ERR_W-1:0] ErrMax  = {ERR_W{1'b1}};

    // State and registered outputs
    state_e             r_state;
    logic [POS_W-1:0]   r_pos;
    logic               r_valid;
    logic               r_lap_pulse;
    logic               r_err_pulse;
    logic [LAP_W-1:0]   r_lap_cnt;
    logic [ERR_W-1:0]   r_err_cnt;

    // Next-state values
    state_e             w_state_d;
    logic [POS_W-1:0]   w_pos_d;
    logic               w_valid_d;
    logic               w_lap_pulse_d;
    logic               w_err_pulse_d;
    logic [LAP_W-1:0]   w_lap_cnt_d;
    logic [ERR_W-1:0]   w_err_cnt_d;

    // Decode
    logic [POS_W-1:0]   w_dec_pos;
    logic               w_legal;
    logic               w_is_msb;
    logic [POS_W-1:0]   w_expected;
    logic               w_match;

    // Clearing the lowest set bit leaves zero only for one-hot or all-zero buses.
    assign w_legal  = ((LED_in & (LED_in - WIDTH'(1))) == '0);
    assign w_is_msb = (LED_in == LedMsb);

    // Position of the set bit counted from the MSB. Only meaningful when w_legal is high.
    always_comb begin
        w_dec_pos = PosOff;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (LED_in[i]) begin
                w_dec_pos = POS_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

    // After all-off the chase restarts at the MSB.
    assign w_expected = (r_pos == PosOff) ? '0 : r_pos + POS_W'(1);
    assign w_match    = w_legal && (w_dec_pos == w_expected);

    // Next-state logic
    always_comb begin
        w_state_d     = r_state;
        w_pos_d       = r_pos;
        w_valid_d     = r_valid;
        w_lap_pulse_d = 1'b0;
        w_err_pulse_d = 1'b0;
        w_lap_cnt_d   = r_lap_cnt;
        w_err_cnt_d   = r_err_cnt;

        if (En) begin
            w_valid_d = w_legal;
            unique case (r_state)
                StUnlocked: begin
                    if (w_legal) begin
                        w_pos_d = w_dec_pos;
                    end
                    if (w_is_msb) begin
                        w_state_d = StLocked;
                    end
                end
                StLocked: begin
                    if (w_match) begin
                        w_pos_d = w_expected;
                        // Only the all-off -> MSB step closes a lap.
                        if (r_pos == PosOff) begin
                            w_lap_pulse_d = 1'b1;
                            w_lap_cnt_d   = r_lap_cnt + LAP_W'(1);
                        end
                    end else begin
                        w_err_pulse_d = 1'b1;
                        if (r_err_cnt != ErrMax) begin
                            w_err_cnt_d = r_err_cnt + ERR_W'(1);
                        end
                        if (w_is_msb) begin
                            // Chaser restarted mid-lap: resynchronise without dropping lock.
                            w_pos_d = '0;
                        end else begin
                            w_state_d = StUnlocked;
                            if (w_legal) begin
                                w_pos_d = w_dec_pos;
                            end
                        end
                    end
                end
                default: begin
                    w_state_d = StUnlocked;
                end
            endcase
        end

        // Clear wins over any increment computed above; pulses are unaffected.
        if (Clr) begin
            w_lap_cnt_d = '0;
            w_err_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            r_state     <= StUnlocked;
            r_pos       <= '0;
            r_valid     <= 1'b0;
            r_lap_pulse <= 1'b0;
            r_err_pulse <= 1'b0;
            r_lap_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_pos       <= w_pos_d;
            r_valid     <= w_valid_d;
            r_lap_pulse <= w_lap_pulse_d;
            r_err_pulse <= w_err_pulse_d;
            r_lap_cnt   <= w_lap_cnt_d;
            r_err_cnt   <= w_err_cnt_d;
        end
    end

    assign Pos       = r_pos;
    assign Valid_pat = r_valid;
    assign Locked    = (r_state == StLocked);
    assign Lap_pulse = r_lap_pulse;
    assign Err_pulse = r_err_pulse;
    assign Lap_cnt   = r_lap_cnt;
    assign Err_cnt   = r_err_cnt;

endmodule
